spi_ram_master: RTL and testbench

- SPI initiator that drives the SPI slave / single-port RAM subsystem from the FPGA fabric side.
- Accepts one 10-bit RAM command word from a host handshake and serialises it as an SPI frame on ss_n/sclk/mosi, in mode 0, MSB first.
- For read-data commands (cmd[9:8]=2'b11) it also clocks back 8 bits on miso and returns them to the host.
- Used as the on-chip stimulus/bring-up driver for the slave+RAM pair.

---
 rtl/spi_ram_master_if.sv | 24 ++
 rtl/spi_ram_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_ram_master.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_master_if.sv
// Host command handshake plus SPI pins of the RAM bring-up initiator; one frame per accepted start.
// Host side has no backpressure beyond busy: a start seen while busy or on the done cycle is dropped.
interface spi_ram_master_if;
    logic       start;
    logic [9:0] cmd;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       ss_n;
    logic       sclk;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, cmd, miso,
        output busy, done, rd_data, rd_valid, ss_n, sclk, mosi
    );

    modport slave (
        output start, cmd, miso,
        input  busy, done, rd_data, rd_valid, ss_n, sclk, mosi
    );
endinterface

// File: rtl/spi_ram_master.sv
// SPI mode-0 initiator: serialises an 11-bit command frame, optionally reads back a byte after a turnaround.
// Latency (2N+1)*CLK_DIV cycles from ss_n fall to done; start is ignored while busy or on the done cycle.
module spi_ram_master #(
    parameter int CLK_DIV     = 2,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_ram_master_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_TX    = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_RX    = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(TURN_CYCLES + 16);

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             rd_op_q, rd_op_d;
    logic             ss_n_q, ss_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic tick;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_op_d    = rd_op_q;
        ss_n_d     = ss_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                // done_q blocks a start arriving on the done cycle so ss_n stays high at least one cycle
                if (bus.start && !done_q) begin
                    state_d = S_SETUP;
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = bus.cmd[9];
                    tx_d    = bus.cmd;
                    rd_op_d = (bus.cmd[9:8] == 2'b11);
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = S_TX;
                end
            end
            S_TX: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        // zeros shift in behind the payload, so the 11th fall parks mosi low
                        mosi_d = tx_q[9];
                        tx_d   = {tx_q[8:0], 1'b0};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(10)) begin
                            cnt_d   = '0;
                            state_d = rd_op_q ? S_TURN : S_HOLD;
                        end
                    end
                end
            end
            S_TURN: begin
                mosi_d = 1'b0;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(TURN_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = S_RX;
                        end
                    end
                end
            end
            S_RX: begin
                mosi_d = 1'b0;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[6:0], bus.miso};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d   = '0;
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    state_d = S_IDLE;
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (rd_op_q) begin
                        rd_data_d  = rx_q;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_op_q    <= 1'b0;
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_op_q    <= rd_op_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.ss_n     = ss_n_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: default-timing instance plus a CLK_DIV=1/TURN_CYCLES=1 instance.
module tb_spi_ram_master;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] cmd;
    logic       miso;
    logic       sel;

    int n_chk;
    int n_err;

    spi_ram_master_if if0 ();
    spi_ram_master_if if1 ();

    spi_ram_master #(.CLK_DIV(2), .TURN_CYCLES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    spi_ram_master #(.CLK_DIV(1), .TURN_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

    assign if0.start = start & ~sel;
    assign if0.cmd   = cmd;
    assign if0.miso  = miso;
    assign if1.start = start & sel;
    assign if1.cmd   = cmd;
    assign if1.miso  = miso;

    logic       m_ss_n, m_sclk, m_mosi, m_busy, m_done, m_rd_valid;
    logic [7:0] m_rd_data;

    assign m_ss_n     = sel ? if1.ss_n     : if0.ss_n;
    assign m_sclk     = sel ? if1.sclk     : if0.sclk;
    assign m_mosi     = sel ? if1.mosi     : if0.mosi;
    assign m_busy     = sel ? if1.busy     : if0.busy;
    assign m_done     = sel ? if1.done     : if0.done;
    assign m_rd_valid = sel ? if1.rd_valid : if0.rd_valid;
    assign m_rd_data  = sel ? if1.rd_data  : if0.rd_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-frame observations filled in by run_frame
    int          low_at_done, rises_at_done, done_cnt, rdv_cnt, done_t, relow_t;
    logic [10:0] mosi_bits;
    logic [7:0]  rd_at_done;
    logic        done_at_rise, rdv_at_done, busy_t1, busy_at_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input logic [9:0] c, input logic [7:0] mb, input int turn,
                             input bit hold, input int rst_rise);
        logic prev_sc, prev_ss;
        int   low_cyc, rises, falls, j, target, stop_t;
        low_cyc = 0; rises = 0; falls = 0; stop_t = -1;
        done_cnt = 0; rdv_cnt = 0; done_t = -1; relow_t = -1;
        low_at_done = 0; rises_at_done = 0; mosi_bits = '0; rd_at_done = '0;
        done_at_rise = 1'b0; rdv_at_done = 1'b0; busy_t1 = 1'b0; busy_at_done = 1'b1;
        target  = hold ? 2 : 1;
        prev_sc = 1'b0;
        prev_ss = 1'b1;
        @(negedge clk);
        cmd   = c;
        start = 1'b1;
        miso  = 1'b0;
        for (int t = 1; t < 600; t++) begin
            @(negedge clk);
            if (t == 3) cmd = ~c;
            if (t == 1) busy_t1 = m_busy;
            if (!m_ss_n) low_cyc++;
            if (m_sclk && !prev_sc) begin
                rises++;
                if (rises <= 11) mosi_bits = {mosi_bits[9:0], m_mosi};
            end
            if (!m_sclk && prev_sc) begin
                falls++;
                j    = falls - 11 - turn;
                miso = (j >= 0 && j < 8) ? mb[7-j] : 1'b0;
            end
            if (m_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_t        = t;
                    done_at_rise  = m_ss_n && !prev_ss;
                    rdv_at_done   = m_rd_valid;
                    rd_at_done    = m_rd_data;
                    busy_at_done  = m_busy;
                    low_at_done   = low_cyc;
                    rises_at_done = rises;
                end
                if (done_cnt == target) stop_t = t + 3;
            end
            if (m_rd_valid) rdv_cnt++;
            if (hold && done_t > 0 && relow_t < 0 && !m_ss_n) relow_t = t;
            if (!hold || (done_t > 0 && t >= done_t + 2)) start = 1'b0;
            prev_sc = m_sclk;
            prev_ss = m_ss_n;
            if (rst_rise > 0 && rises == rst_rise) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_mid.ss_n", m_ss_n, 1'b1);
                check("rst_mid.sclk", m_sclk, 1'b0);
                check("rst_mid.busy", m_busy, 1'b0);
                check("rst_mid.done", m_done, 1'b0);
                check("rst_mid.rd_valid", m_rd_valid, 1'b0);
                rst_n = 1'b1;
                break;
            end
            if (t == stop_t) break;
        end
        start = 1'b0;
        miso  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [9:0] c, input int d, input int turn,
                               input logic [7:0] exp_rd, input int exp_done);
        int   n;
        logic is_rd;
        is_rd = (c[9:8] == 2'b11);
        n     = is_rd ? (11 + turn + 8) : 11;
        check({tag, ".ss_low"},    low_at_done,   (2 * n + 1) * d);
        check({tag, ".rises"},     rises_at_done, n);
        check({tag, ".mosi"},      mosi_bits,     {c[9], c});
        check({tag, ".done_t"},    done_t,        (2 * n + 1) * d + 1);
        check({tag, ".done_ssn"},  done_at_rise,  1'b1);
        check({tag, ".busy_t1"},   busy_t1,       1'b1);
        check({tag, ".busy_done"}, busy_at_done,  1'b0);
        check({tag, ".done_cnt"},  done_cnt,      exp_done);
        check({tag, ".rdv_done"},  rdv_at_done,   is_rd);
        check({tag, ".rdv_cnt"},   rdv_cnt,       is_rd ? 1 : 0);
        check({tag, ".rd_data"},   rd_at_done,    exp_rd);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        cmd   = '0;
        miso  = 1'b0;
        sel   = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset.ss_n",     m_ss_n,     1'b1);
            check("reset.sclk",     m_sclk,     1'b0);
            check("reset.mosi",     m_mosi,     1'b0);
            check("reset.busy",     m_busy,     1'b0);
            check("reset.done",     m_done,     1'b0);
            check("reset.rd_valid", m_rd_valid, 1'b0);
            check("reset.rd_data",  m_rd_data,  8'h00);
        end
        sel   = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(10'h0A5, 8'h00, 2, 1'b0, 0);
        check_frame("wr_addr", 10'h0A5, 2, 2, 8'h00, 1);
        run_frame(10'h1C3, 8'h00, 2, 1'b0, 0);
        check_frame("wr_data", 10'h1C3, 2, 2, 8'h00, 1);
        run_frame(10'h2A5, 8'h00, 2, 1'b0, 0);
        check_frame("rd_addr", 10'h2A5, 2, 2, 8'h00, 1);
        run_frame(10'h300, 8'h3C, 2, 1'b0, 0);
        check_frame("rd_data", 10'h300, 2, 2, 8'h3C, 1);
        run_frame(10'h0A5, 8'h00, 2, 1'b0, 0);
        check_frame("rd_hold", 10'h0A5, 2, 2, 8'h3C, 1);

        // start held through the frame with cmd changed mid-flight; second frame follows done
        run_frame(10'h1C3, 8'h00, 2, 1'b1, 0);
        check_frame("held", 10'h1C3, 2, 2, 8'h3C, 2);
        check("held.regap", relow_t, done_t + 2);

        run_frame(10'h2A5, 8'h00, 2, 1'b0, 5);
        check("rst_mid.no_done", done_cnt, 0);
        repeat (2) @(negedge clk);
        check("rst_mid.rd_data", m_rd_data, 8'h00);
        run_frame(10'h0A5, 8'h00, 2, 1'b0, 0);
        check_frame("post_rst", 10'h0A5, 2, 2, 8'h00, 1);

        sel = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(10'h300, 8'hA5, 1, 1'b0, 0);
        check_frame("div1_rd", 10'h300, 1, 1, 8'hA5, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
